// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption controller: owns state/round-key registers and steps
// an external combinational round datapath once per clock, with valid/ready on both sides.
module aes_round_sequencer #(
    parameter int NUM_ROUNDS = 10,
    parameter int DATA_W     = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] plaintext,
    input  logic [DATA_W-1:0] key,
    output logic [DATA_W-1:0] dp_state,
    output logic [DATA_W-1:0] dp_key,
    output logic [3:0]        dp_round,
    output logic              dp_final,
    input  logic [DATA_W-1:0] dp_next_key,
    input  logic [DATA_W-1:0] dp_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ciphertext,
    output logic              busy
);

    // state | meaning
    // IDLE  | waiting for a block, in_ready high
    // RUN   | one cipher round per clock, dp_round = 1..NUM_ROUNDS
    // DONE  | ciphertext held with out_valid until out_ready
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);
    localparam logic [3:0] PRE_LAST = 4'(NUM_ROUNDS - 1);

    fsm_t              r_fsm;
    logic [DATA_W-1:0] r_state;
    logic [DATA_W-1:0] r_key;
    logic [DATA_W-1:0] r_ct;
    logic [3:0]        r_round_cnt;
    logic              r_final;
    logic              r_out_valid;
    logic              r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= S_IDLE;
            r_state     <= '0;
            r_key       <= '0;
            r_ct        <= '0;
            r_round_cnt <= 4'd0;
            r_final     <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state     <= plaintext ^ key;
                        r_key       <= key;
                        r_round_cnt <= 4'd1;
                        r_final     <= (LAST_RND == 4'd1);
                        r_busy      <= 1'b1;
                        r_fsm       <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_state <= dp_result;
                    r_key   <= dp_next_key;
                    if (r_round_cnt == LAST_RND) begin
                        // round counter parks at 0 so dp_round reads 0 outside RUN
                        r_ct        <= dp_result;
                        r_round_cnt <= 4'd0;
                        r_final     <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_fsm       <= S_DONE;
                    end else begin
                        r_round_cnt <= r_round_cnt + 4'd1;
                        r_final     <= (r_round_cnt == PRE_LAST);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_fsm       <= S_IDLE;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_fsm == S_IDLE);
    assign dp_state   = r_state;
    assign dp_key     = r_key;
    assign dp_round   = r_round_cnt;
    assign dp_final   = r_final;
    assign out_valid  = r_out_valid;
    assign ciphertext = r_ct;
    assign busy       = r_busy;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: supplies a reference AES round datapath and checks
// ciphertexts against FIPS-197 vectors and a whole-block AES-128 model.
module tb_aes_round_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic [127:0] dp_state;
    logic [127:0] dp_key;
    logic [3:0]   dp_round;
    logic         dp_final;
    logic [127:0] dp_next_key;
    logic [127:0] dp_result;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    aes_round_sequencer #(.NUM_ROUNDS(10), .DATA_W(128)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .key(key), .dp_state(dp_state), .dp_key(dp_key),
        .dp_round(dp_round), .dp_final(dp_final), .dp_next_key(dp_next_key),
        .dp_result(dp_result), .out_valid(out_valid), .out_ready(out_ready),
        .ciphertext(ciphertext), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] blk_t [16];

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] a = a_in;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xtime(a);
        end
        return p;
    endfunction

    // multiplicative inverse as x^254, then the AES affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        logic [7:0] b = x;
        logic [7:0] e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, b);
            b = gmul(b, b);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic blk_t to_arr(input logic [127:0] s);
        blk_t a;
        for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
        return a;
    endfunction

    function automatic logic [127:0] from_arr(input blk_t a);
        logic [127:0] s = '0;
        for (int i = 0; i < 16; i++) s[127-8*i -: 8] = a[i];
        return s;
    endfunction

    function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] rk,
                                              input logic fin);
        blk_t a = to_arr(s);
        blk_t b;
        blk_t m;
        for (int i = 0; i < 16; i++) a[i] = sbox(a[i]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[r+4*c] = a[r+4*((c+r)%4)];
        m = b;
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                m[4*c]   = gmul(8'h02, b[4*c]) ^ gmul(8'h03, b[4*c+1]) ^ b[4*c+2] ^ b[4*c+3];
                m[4*c+1] = b[4*c] ^ gmul(8'h02, b[4*c+1]) ^ gmul(8'h03, b[4*c+2]) ^ b[4*c+3];
                m[4*c+2] = b[4*c] ^ b[4*c+1] ^ gmul(8'h02, b[4*c+2]) ^ gmul(8'h03, b[4*c+3]);
                m[4*c+3] = gmul(8'h03, b[4*c]) ^ b[4*c+1] ^ b[4*c+2] ^ gmul(8'h02, b[4*c+3]);
            end
        end
        return from_arr(m) ^ rk;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input int rnd);
        logic [7:0]  rc = 8'h01;
        logic [31:0] w0, w1, w2, w3, t;
        for (int i = 1; i < rnd; i++) rc = xtime(rc);
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k_in);
        logic [127:0] s = pt ^ k_in;
        logic [127:0] k = k_in;
        for (int r = 1; r <= 10; r++) begin
            k = key_step(k, r);
            s = round_fn(s, k, r == 10);
        end
        return s;
    endfunction

    always_comb begin
        dp_next_key = key_step(dp_key, int'(dp_round));
        dp_result   = round_fn(dp_state, dp_next_key, dp_final);
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One full block; accept edge counts as edge 1, so out_valid must appear after edge 11.
    task automatic do_block(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] exp,
                            input int hold, input bit noise, input logic [127:0] npt,
                            input logic [127:0] nk);
        int waited = 0;
        @(negedge clk);
        plaintext = pt; key = k; in_valid = 1'b1; out_ready = 1'b0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check_val("accept_timeout", 128'(in_ready), 128'(1));
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (noise) begin plaintext = npt; key = nk; end
        else in_valid = 1'b0;
        check_val("init_ark", dp_state, pt ^ k);
        check_val("init_key", dp_key, k);
        for (int r = 1; r <= 10; r++) begin
            check_val("dp_round", 128'(dp_round), 128'(r));
            check_val("dp_final", 128'(dp_final), 128'(r == 10));
            check_val("run_out_valid", 128'(out_valid), 128'(0));
            check_val("run_in_ready", 128'(in_ready), 128'(0));
            check_val("run_busy", 128'(busy), 128'(1));
            @(posedge clk); #1;
        end
        check_val("done_out_valid", 128'(out_valid), 128'(1));
        check_val("ct", ciphertext, exp);
        check_val("done_round", 128'(dp_round), 128'(0));
        check_val("done_final", 128'(dp_final), 128'(0));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check_val("hold_out_valid", 128'(out_valid), 128'(1));
            check_val("hold_ct", ciphertext, exp);
            check_val("hold_in_ready", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("hs_out_valid", 128'(out_valid), 128'(0));
        check_val("hs_in_ready", 128'(in_ready), 128'(1));
        check_val("hs_busy", 128'(busy), 128'(0));
        check_val("hs_ct_kept", ciphertext, exp);
    endtask

    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] pa, ka, pb, kb;
        logic [127:0] exp_q [$];
        int last_acc, n_acc, n_out;
        bit acc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0; key = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready", 128'(in_ready), 128'(1));
        check_val("rst_out_valid", 128'(out_valid), 128'(0));
        check_val("rst_busy", 128'(busy), 128'(0));
        check_val("rst_ct", ciphertext, 128'(0));
        check_val("rst_state", dp_state, 128'(0));
        check_val("rst_key", dp_key, 128'(0));
        check_val("rst_round", 128'(dp_round), 128'(0));
        check_val("rst_final", 128'(dp_final), 128'(0));
        rst = 1'b0;

        // FIPS vectors; first one also holds out_ready low for 20 cycles
        do_block(PT1, K1, CT1, 20, 1'b0, '0, '0);
        do_block(PT2, K2, CT2, 0, 1'b0, '0, '0);

        // new data presented during RUN must be ignored, then accepted once IDLE
        pa = rnd128(); ka = rnd128(); pb = rnd128(); kb = rnd128();
        do_block(pa, ka, aes_ref(pa, ka), 2, 1'b1, pb, kb);
        do_block(pb, kb, aes_ref(pb, kb), 1, 1'b0, '0, '0);

        for (int i = 0; i < 4; i++) begin
            pa = rnd128(); ka = rnd128();
            do_block(pa, ka, aes_ref(pa, ka), int'($urandom_range(0, 3)), 1'b0, '0, '0);
        end

        // abort at round 5
        @(negedge clk);
        plaintext = rnd128(); key = rnd128(); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_val("abort_round", 128'(dp_round), 128'(5));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("abort_in_ready", 128'(in_ready), 128'(1));
        check_val("abort_out_valid", 128'(out_valid), 128'(0));
        check_val("abort_busy", 128'(busy), 128'(0));
        check_val("abort_round0", 128'(dp_round), 128'(0));
        check_val("abort_state", dp_state, 128'(0));
        check_val("abort_ct", ciphertext, 128'(0));
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            check_val("abort_no_ct", 128'(out_valid), 128'(0));
        end
        do_block(PT1, K1, CT1, 0, 1'b0, '0, '0);

        // reset beats a simultaneous in_valid
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; plaintext = PT2; key = K2;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        check_val("rstv_in_ready", 128'(in_ready), 128'(1));
        check_val("rstv_busy", 128'(busy), 128'(0));
        check_val("rstv_state", dp_state, 128'(0));

        // back-to-back with in_valid and out_ready tied high
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; plaintext = rnd128(); key = rnd128();
        last_acc = -1; n_acc = 0; n_out = 0;
        for (int cyc = 0; cyc < 90; cyc++) begin
            acc = in_ready && in_valid;
            if (acc) begin
                exp_q.push_back(aes_ref(plaintext, key));
                if (last_acc >= 0) check_val("b2b_interval", 128'(cyc - last_acc), 128'(12));
                last_acc = cyc;
                n_acc++;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) check_val("b2b_unexpected_ct", 128'(1), 128'(0));
                else check_val("b2b_ct", ciphertext, exp_q.pop_front());
                n_out++;
            end
            @(negedge clk);
            if (acc) begin plaintext = rnd128(); key = rnd128(); end
        end
        in_valid = 1'b0;
        check_val("b2b_accepts", 128'(n_acc), 128'(8));
        check_val("b2b_outputs", 128'(n_out), 128'(7));
        repeat (20) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
